// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the 6510 bus arbiter (RDY/AEC generation).
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARN  = 2'd1,
        GRANT = 2'd2
    } arb_state_e;

    localparam int unsigned BA_LEAD_DEFAULT = 3;

    // Width of a counter that must reach ba_lead, never narrower than one bit.
    function automatic int unsigned lead_cnt_w(input int unsigned ba_lead);
        int unsigned w;
        w = $clog2(ba_lead + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Drives CPU RDY/AEC from the VIC-II DMA request with a BA warning window and
// counts stolen cycles. Optional write-during-grant check: BUS_VIOLATION_CHECK_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned BA_LEAD = BA_LEAD_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cyc_en,
    input  logic             dma_req,
    input  logic             cpu_we,
    input  logic             cnt_clr,
    output logic             ba,
    output logic             rdy,
    output logic             aec,
    output logic             vic_grant,
    output logic [CNT_W-1:0] stolen_cnt,
    output logic             violation
);

    localparam int unsigned LEAD_W = lead_cnt_w(BA_LEAD);

    arb_state_e        state_q, state_d;
    logic [LEAD_W-1:0] lead_q, lead_d;
    logic              ba_q, ba_d;
    logic              aec_q, aec_d;
    logic              grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state and next-output logic; everything advances only on cyc_en.
    always_comb begin
        state_d = state_q;
        lead_d  = lead_q;
        ba_d    = ba_q;
        aec_d   = aec_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;

        if (cyc_en) begin
            case (state_q)
                IDLE: begin
                    if (dma_req) begin
                        ba_d = 1'b0;
                        if (BA_LEAD == 0) begin
                            state_d = GRANT;
                            aec_d   = 1'b0;
                            grant_d = 1'b1;
                        end else begin
                            state_d = WARN;
                            lead_d  = LEAD_W'(1);
                        end
                    end
                end
                WARN: begin
                    if (!dma_req) begin
                        state_d = IDLE;
                        ba_d    = 1'b1;
                        lead_d  = '0;
                    end else if (lead_q == LEAD_W'(BA_LEAD)) begin
                        state_d = GRANT;
                        aec_d   = 1'b0;
                        grant_d = 1'b1;
                    end else begin
                        lead_d = LEAD_W'(lead_q + LEAD_W'(1));
                    end
                end
                GRANT: begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                    if (!dma_req) begin
                        state_d = IDLE;
                        ba_d    = 1'b1;
                        aec_d   = 1'b1;
                        grant_d = 1'b0;
                        lead_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ba_d    = 1'b1;
                    aec_d   = 1'b1;
                    grant_d = 1'b0;
                    lead_d  = '0;
                end
            endcase
        end

        // Clear beats a coincident increment and works without cyc_en.
        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lead_q  <= '0;
            ba_q    <= 1'b1;
            aec_q   <= 1'b1;
            grant_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lead_q  <= lead_d;
            ba_q    <= ba_d;
            aec_q   <= aec_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ba         = ba_q;
    assign rdy        = ba_q;
    assign aec        = aec_q;
    assign vic_grant  = grant_q;
    assign stolen_cnt = cnt_q;

`ifdef BUS_VIOLATION_CHECK_EN
    logic viol_q;

    // Sticky: the CPU tried to write while the VIC owned the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol_q <= 1'b0;
        end else if (cnt_clr) begin
            viol_q <= 1'b0;
        end else if (cyc_en && (state_q == GRANT) && cpu_we) begin
            viol_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && cyc_en && (state_q == GRANT) && cpu_we) begin
            $error("bus_arbiter: CPU write while AEC=0");
        end
    end

    assign violation = viol_q;
`else
    logic unused_cpu_we;
    assign unused_cpu_we = cpu_we;
    assign violation     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised scoreboard bench for bus_arbiter against a run-length reference model.
module tb_bus_arbiter;

    localparam int unsigned LEAD = 3;
    localparam int unsigned CW   = 6;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cyc_en = 1'b0;
    logic          dma_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          ba, rdy, aec, vic_grant, violation;
    logic [CW-1:0] stolen_cnt;

    bus_arbiter #(.BA_LEAD(LEAD), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cyc_en     (cyc_en),
        .dma_req    (dma_req),
        .cpu_we     (cpu_we),
        .cnt_clr    (cnt_clr),
        .ba         (ba),
        .rdy        (rdy),
        .aec        (aec),
        .vic_grant  (vic_grant),
        .stolen_cnt (stolen_cnt),
        .violation  (violation)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ba;
        logic          aec;
        logic          vg;
        logic          viol;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Model: length of the current run of sampled dma_req=1 strobes.
    // Bus is warned while 1..LEAD, granted beyond LEAD.
    int   m_run = 0;
    int   m_cnt = 0;
    logic m_viol = 1'b0;

    function automatic void model_reset();
        m_run  = 0;
        m_cnt  = 0;
        m_viol = 1'b0;
    endfunction

    function automatic void model_edge();
        bit was_grant;
        if (!reset_n) begin
            model_reset();
            return;
        end
        was_grant = (m_run > int'(LEAD));
        if (cyc_en) begin
            m_run = dma_req ? ((m_run > int'(LEAD)) ? m_run : m_run + 1) : 0;
        end
`ifdef BUS_VIOLATION_CHECK_EN
        if (cnt_clr) m_viol = 1'b0;
        else if (cyc_en && was_grant && cpu_we) m_viol = 1'b1;
`endif
        if (cnt_clr) m_cnt = 0;
        else if (cyc_en && was_grant && m_cnt < CMAX) m_cnt = m_cnt + 1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.ba   = (m_run == 0);
        e.aec  = (m_run <= int'(LEAD));
        e.vg   = !e.aec;
        e.viol = m_viol;
        e.cnt  = CW'(m_cnt);
        return e;
    endfunction

    // One clk cycle of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic step(input logic c, input logic r, input logic w, input logic k);
        @(negedge clk);
        cyc_en  = c;
        dma_req = r;
        cpu_we  = w;
        cnt_clr = k;
        model_edge();
        q.push_back(model_out());
    endtask

    // CPU cycle of `per` clks: strobe on the first, random glitches on dma_req after.
    task automatic cpu_cycle(input int per, input logic r, input logic w);
        step(1'b1, r, w, 1'b0);
        for (int i = 1; i < per; i++) begin
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
        end
    endtask

    task automatic check_now(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every registered output one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (ba !== e.ba || rdy !== e.ba || aec !== e.aec || vic_grant !== e.vg ||
                    violation !== e.viol || stolen_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: got ba=%b rdy=%b aec=%b vg=%b viol=%b cnt=%0d expected ba=%b aec=%b vg=%b viol=%b cnt=%0d",
                             $time, ba, rdy, aec, vic_grant, violation, stolen_cnt,
                             e.ba, e.aec, e.vg, e.viol, e.cnt);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 5 clk.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        reset_n = 1'b1;
        check_now("reset_ba", int'(ba), 1);
        check_now("reset_aec", int'(aec), 1);
        check_now("reset_cnt", int'(stolen_cnt), 0);

        // Nominal steal: 43 strobes requested, then released.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 43; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 0) begin
                settle();
                check_now("nominal_ba_edge0", int'(ba), 0);
                check_now("nominal_aec_edge0", int'(aec), 1);
            end
            if (i == 3) begin
                settle();
                check_now("nominal_aec_edge3", int'(aec), 0);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check_now("nominal_release_aec", int'(aec), 1);
        check_now("nominal_stolen", int'(stolen_cnt), 40);

        // Abort in WARN: 2 strobes requested, cpu writes during WARN.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check_now("abort_ba_low", int'(ba), 0);
        check_now("abort_aec_high", int'(aec), 1);
        check_now("abort_no_violation", int'(violation), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check_now("abort_ba_back", int'(ba), 1);
        check_now("abort_cnt_same", int'(stolen_cnt), 40);

        // Saturation, then write during GRANT, then clear coincident with increment.
        for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        check_now("saturate", int'(stolen_cnt), CMAX);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        check_now("clear_wins", int'(stolen_cnt), 0);
        check_now("clear_violation", int'(violation), 0);

        // Gated strobes every 8 clk with glitching dma_req in between.
        for (int i = 0; i < 12; i++) cpu_cycle(8, 1'($urandom_range(1)), 1'b0);
        for (int i = 0; i < 8; i++) cpu_cycle(8, 1'b1, 1'b0);

        // Async reset mid-GRANT.
        settle();
        check_now("pre_reset_grant", int'(vic_grant), 1);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_now("async_reset_ba", int'(ba), 1);
        check_now("async_reset_aec", int'(aec), 1);
        check_now("async_reset_vg", int'(vic_grant), 0);
        check_now("async_reset_cnt", int'(stolen_cnt), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        reset_n = 1'b1;

        // Random bursts with random strobe spacing, writes and clears.
        for (int b = 0; b < 60; b++) begin
            int per;
            int len;
            per = $urandom_range(4, 1);
            len = $urandom_range(9, 1);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(15) == 0) step(1'b0, 1'b1, 1'b0, 1'b1);
                cpu_cycle(per, 1'b1, 1'($urandom_range(3) == 0));
            end
            len = $urandom_range(3, 1);
            for (int i = 0; i < len; i++) cpu_cycle(per, 1'b0, 1'($urandom_range(1)));
        end

        settle();
        settle();
        check_now("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Upstream companion of the 6510 CPU wrapper. Generates the CPU's RDY and AEC inputs from the VIC-II DMA request (bad-line and sprite fetches).
- Implements the standard BA warning window: BA falls, the CPU may finish up to BA_LEAD cycles (its pending writes), then AEC falls and the VIC owns the bus.
- Counts stolen cycles so software-visible timing can be checked in simulation.

Parameters:
- BA_LEAD, 3: CPU cycles between BA falling and AEC falling.
- CNT_W, 16: width of the stolen-cycle counter.

Ports:
- clk, input, 1: system clock. Single clock domain.
- reset_n, input, 1: asynchronous, active-low reset.
- cyc_en, input, 1: one-clk strobe marking each CPU cycle boundary (phi2 falling). All state changes occur only on clk edges where cyc_en=1.
- dma_req, input, 1: level from the VIC sequencer. 1 = VIC needs the bus in coming cycles.
- cpu_we, input, 1: CPU write enable for the current cycle.
- cnt_clr, input, 1: synchronous clear of stolen_cnt (acts on any clk edge).
- ba, output, 1: bus available. 0 = warning or VIC ownership.
- rdy, output, 1: to CPU RDY. Equals ba.
- aec, output, 1: to CPU AEC. 1 = CPU drives the bus.
- vic_grant, output, 1: VIC may drive the address bus this cycle. Equals ~aec.
- stolen_cnt, output, CNT_W: count of CPU cycles spent in GRANT, saturating.
- violation, output, 1: sticky write-during-grant flag. Present only with the optional feature, otherwise tied 0.

Behaviour:
- All outputs are registered. Reset values: ba=1, rdy=1, aec=1, vic_grant=0, stolen_cnt=0, violation=0, state=IDLE, lead counter=0.
- States are IDLE, WARN and GRANT. All transitions are evaluated only when cyc_en=1.
- IDLE:
  - dma_req=1 -> WARN. Same edge: ba=rdy=0, lead counter=1.
  - Special case BA_LEAD=0: go directly to GRANT, with ba=0 and aec=0 on the same edge.
  - dma_req=0 -> stay in IDLE.
- WARN:
  - dma_req=0 -> abort to IDLE. Same edge: ba=rdy=1. aec was never dropped.
  - Else if lead counter==BA_LEAD -> GRANT. Same edge: aec=0, vic_grant=1.
  - Else lead counter increments.
  - aec stays 1 throughout WARN. With BA_LEAD=3, AEC falls exactly 3 cyc_en edges after BA falls.
- GRANT:
  - dma_req=0 -> IDLE. Same edge: ba=rdy=aec=1, vic_grant=0. The CPU resumes on the next cycle.
  - Else stay in GRANT.
  - Each cyc_en edge that ends a GRANT cycle increments stolen_cnt. This includes the edge on which GRANT is left.
- stolen_cnt:
  - Saturates at all-ones and does not wrap.
  - If cnt_clr and an increment occur on the same edge, cnt_clr wins and the result is 0.
- Lead counter width is clog2(BA_LEAD+1), minimum 1 bit.
- cyc_en=0: all state and outputs hold. cnt_clr still acts.
- Reset asserted mid-GRANT: outputs return immediately (asynchronously) to reset values. On reset release the CPU owns the bus.
- dma_req glitches between cyc_en strobes are ignored. Only its value on cyc_en edges matters.

Optional Feature:
- Macro: BUS_VIOLATION_CHECK_EN.
- Defined:
  - violation is set when cyc_en=1, state=GRANT and cpu_we=1 (the CPU attempted to drive the bus while AEC=0).
  - violation is sticky and is cleared only by reset_n or cnt_clr.
  - In simulation, a $error message is also emitted.
- Undefined: violation is a constant 0 and no checking logic is built.

Decomposition:
- Package bus_arb_pkg holds:
  - the state enum (IDLE, WARN, GRANT);
  - the BA_LEAD default constant;
  - a function returning the lead counter width.
- No sub-module. The saturating counter is inline, since it is small.

Test Plan:
- Reset: hold reset_n=0 for 5 clk -> ba=1, aec=1, vic_grant=0, stolen_cnt=0. Assert reset_n=0 during GRANT -> ba and aec rise without waiting for cyc_en.
- Nominal steal: dma_req=1 for 43 cycles, then 0 -> ba falls at edge 0, aec falls at edge 3, both rise at edge 43. stolen_cnt=40.
- Abort in WARN: dma_req=1 for 2 cycles, then 0 -> ba low for exactly 2 cycles, aec never 0, stolen_cnt unchanged.
- cyc_en gating: dma_req toggles between strobes with cyc_en every 8 clk -> state changes only on strobe edges. Pulses narrower than 8 clk that miss a strobe have no effect.
- Saturation and clear: with CNT_W=4, run a 20-cycle GRANT -> stolen_cnt=15. cnt_clr coincident with an increment -> stolen_cnt=0.
- Violation (with BUS_VIOLATION_CHECK_EN): cpu_we=1 during WARN -> violation=0. cpu_we=1 during GRANT -> violation=1 and it stays 1 until cnt_clr.
